alu_ctrl_pipe: RTL and testbench

ALU_CTRL_PIPE -- requirements
Module: alu_ctrl_pipe

---
 rtl/alu_ctrl_pkg.sv | 55 +++++
 rtl/alu_ctrl_decode.sv | 125 ++++++++++++
 rtl/alu_ctrl_pipe.sv | 124 ++++++++++++
 tb/tb_alu_ctrl_pipe.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_pkg
// Description : Shared ALU op classes, 5-bit ALU control codes and funct7
//               field constants used by the decoder and the ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_ctrl_pkg;

  // Op class from the main decoder
  typedef enum logic [3:0] {
    OP_ADDR  = 4'b0000,
    OP_ARITH = 4'b0001,
    OP_LOGIC = 4'b0010,
    OP_SHIFT = 4'b0011,
    OP_CMP   = 4'b0100,
    OP_ZBA   = 4'b0101
  } alu_op_e;

  // ALU select codes; 00000-10000 keep the legacy ALU map
  typedef enum logic [4:0] {
    CTRL_ADD       = 5'b00000,
    CTRL_SUB       = 5'b00001,
    CTRL_AND       = 5'b00010,
    CTRL_OR        = 5'b00011,
    CTRL_XOR       = 5'b00100,
    CTRL_SLL       = 5'b00101,
    CTRL_SRL       = 5'b00110,
    CTRL_SRA       = 5'b00111,
    CTRL_SLT       = 5'b01000,
    CTRL_SLTU      = 5'b01001,
    CTRL_SH1ADD    = 5'b01010,
    CTRL_SH2ADD    = 5'b01011,
    CTRL_SH3ADD    = 5'b01100,
    CTRL_ADD_UW    = 5'b01101,
    CTRL_SH1ADD_UW = 5'b01110,
    CTRL_SH2ADD_UW = 5'b01111,
    CTRL_SH3ADD_UW = 5'b10000,
    CTRL_ADDW      = 5'b10001,
    CTRL_SUBW      = 5'b10010,
    CTRL_SLLW      = 5'b10011,
    CTRL_SRLW      = 5'b10100,
    CTRL_SRAW      = 5'b10101,
    CTRL_SLLI_UW   = 5'b10110
  } alu_ctrl_e;

  // funct7 encodings
  localparam logic [6:0] c_f7_zero       = 7'b0000000;
  localparam logic [6:0] c_f7_alt        = 7'b0100000;
  localparam logic [6:0] c_f7_zba_sh     = 7'b0010000;
  localparam logic [6:0] c_f7_add_uw     = 7'b0000100;
  localparam logic [5:0] c_f7_slli_uw_hi = 6'b000010;

endpackage
`default_nettype wire

// File: rtl/alu_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_decode
// Description : Combinational ALU-control decode: op class + instruction
//               fields -> 5-bit ALU select and illegal flag.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int ENABLE_ZBA   = 1,
  parameter int ENABLE_RV64W = 1
) (
  input  logic [3:0] i_alu_op,
  input  logic [2:0] i_funct3,
  input  logic [6:0] i_funct7,
  input  logic       i_is_imm,
  input  logic       i_word,
  output logic [4:0] o_ctrl,
  output logic       o_illegal
);

  logic [4:0] w_ctrl;
  logic       w_legal;
  logic [6:0] w_f7_shift;
  logic       w_f7_zero;

  // Field decode; anything not explicitly matched stays illegal
  always_comb begin
    w_ctrl     = CTRL_ADD;
    w_legal    = 1'b0;
    // RV64 immediate shifts use funct7[0] as shamt[5]
    w_f7_shift = (i_is_imm && !i_word) ? {i_funct7[6:1], 1'b0} : i_funct7;
    // I-type forms of logic/compare carry immediate bits in funct7
    w_f7_zero  = i_is_imm || (i_funct7 == c_f7_zero);

    case (i_alu_op)
      OP_ADDR: begin
        w_ctrl  = CTRL_ADD;
        w_legal = 1'b1;
      end
      OP_ARITH: begin
        if (i_funct3 == 3'b000) begin
          if (i_is_imm || (i_funct7 == c_f7_zero)) begin
            w_ctrl  = i_word ? CTRL_ADDW : CTRL_ADD;
            w_legal = 1'b1;
          end else if (i_funct7 == c_f7_alt) begin
            w_ctrl  = i_word ? CTRL_SUBW : CTRL_SUB;
            w_legal = 1'b1;
          end
        end
      end
      OP_LOGIC: begin
        if (!i_word && w_f7_zero) begin
          case (i_funct3)
            3'b111:  begin w_ctrl = CTRL_AND; w_legal = 1'b1; end
            3'b110:  begin w_ctrl = CTRL_OR;  w_legal = 1'b1; end
            3'b100:  begin w_ctrl = CTRL_XOR; w_legal = 1'b1; end
            default: w_legal = 1'b0;
          endcase
        end
      end
      OP_SHIFT: begin
        case (i_funct3)
          3'b001: begin
            if (w_f7_shift == c_f7_zero) begin
              w_ctrl  = i_word ? CTRL_SLLW : CTRL_SLL;
              w_legal = 1'b1;
            end
          end
          3'b101: begin
            if (w_f7_shift == c_f7_zero) begin
              w_ctrl  = i_word ? CTRL_SRLW : CTRL_SRL;
              w_legal = 1'b1;
            end else if (w_f7_shift == c_f7_alt) begin
              w_ctrl  = i_word ? CTRL_SRAW : CTRL_SRA;
              w_legal = 1'b1;
            end
          end
          default: w_legal = 1'b0;
        endcase
      end
      OP_CMP: begin
        if (!i_word && w_f7_zero) begin
          case (i_funct3)
            3'b010:  begin w_ctrl = CTRL_SLT;  w_legal = 1'b1; end
            3'b011:  begin w_ctrl = CTRL_SLTU; w_legal = 1'b1; end
            default: w_legal = 1'b0;
          endcase
        end
      end
      OP_ZBA: begin
        if (i_is_imm) begin
          if (i_word && (i_funct3 == 3'b001) && (i_funct7[6:1] == c_f7_slli_uw_hi)) begin
            w_ctrl  = CTRL_SLLI_UW;
            w_legal = 1'b1;
          end
        end else if (i_funct7 == c_f7_zba_sh) begin
          case (i_funct3)
            3'b010:  begin w_ctrl = i_word ? CTRL_SH1ADD_UW : CTRL_SH1ADD; w_legal = 1'b1; end
            3'b100:  begin w_ctrl = i_word ? CTRL_SH2ADD_UW : CTRL_SH2ADD; w_legal = 1'b1; end
            3'b110:  begin w_ctrl = i_word ? CTRL_SH3ADD_UW : CTRL_SH3ADD; w_legal = 1'b1; end
            default: w_legal = 1'b0;
          endcase
        end else if (i_word && (i_funct7 == c_f7_add_uw) && (i_funct3 == 3'b000)) begin
          w_ctrl  = CTRL_ADD_UW;
          w_legal = 1'b1;
        end
        if (ENABLE_ZBA == 0) begin
          w_legal = 1'b0;
        end
      end
      default: w_legal = 1'b0;
    endcase

    if ((ENABLE_RV64W == 0) && i_word) begin
      w_legal = 1'b0;
    end
  end

  assign o_ctrl    = w_legal ? w_ctrl : CTRL_ADD;
  assign o_illegal = ~w_legal;

endmodule
`default_nettype wire

// File: rtl/alu_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_pipe
// Description : ALU-control decode followed by a two-entry skid buffer
//               (R0 output register, R1 skid register) with flush and a
//               saturating count of delivered illegal ops.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_ctrl_pipe
  import alu_ctrl_pkg::*;
#(
  parameter int TAG_W        = 8,
  parameter int CNT_W        = 16,
  parameter int ENABLE_ZBA   = 1,
  parameter int ENABLE_RV64W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_alu_op,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic             in_is_imm,
  input  logic             in_word,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_alu_ctrl,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] illegal_cnt
);

  logic [4:0]       w_dec_ctrl;
  logic             w_dec_illegal;
  logic             w_in_fire;
  logic             w_out_fire;

  logic             r_r0_valid;
  logic [4:0]       r_r0_ctrl;
  logic             r_r0_illegal;
  logic [TAG_W-1:0] r_r0_tag;
  logic             r_r1_valid;
  logic [4:0]       r_r1_ctrl;
  logic             r_r1_illegal;
  logic [TAG_W-1:0] r_r1_tag;
  logic [CNT_W-1:0] r_illegal_cnt;

  alu_ctrl_decode #(
    .ENABLE_ZBA   (ENABLE_ZBA),
    .ENABLE_RV64W (ENABLE_RV64W)
  ) u_decode (
    .i_alu_op  (in_alu_op),
    .i_funct3  (in_funct3),
    .i_funct7  (in_funct7),
    .i_is_imm  (in_is_imm),
    .i_word    (in_word),
    .o_ctrl    (w_dec_ctrl),
    .o_illegal (w_dec_illegal)
  );

  // in_ready comes straight from a flop: no combinational path from in_valid/out_ready
  assign in_ready   = ~r_r1_valid;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = r_r0_valid & out_ready;

  // Skid buffer: fill R0 when empty/draining, else R1; R1 refills R0 on drain
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_r0_valid   <= 1'b0;
      r_r0_ctrl    <= CTRL_ADD;
      r_r0_illegal <= 1'b0;
      r_r0_tag     <= '0;
      r_r1_valid   <= 1'b0;
      r_r1_ctrl    <= CTRL_ADD;
      r_r1_illegal <= 1'b0;
      r_r1_tag     <= '0;
    end else if (flush) begin
      r_r0_valid <= 1'b0;
      r_r1_valid <= 1'b0;
    end else if (r_r1_valid) begin
      // in_ready is low here, so no new op can arrive this cycle
      if (w_out_fire) begin
        r_r0_ctrl    <= r_r1_ctrl;
        r_r0_illegal <= r_r1_illegal;
        r_r0_tag     <= r_r1_tag;
        r_r1_valid   <= 1'b0;
      end
    end else if (w_in_fire) begin
      if (!r_r0_valid || out_ready) begin
        r_r0_valid   <= 1'b1;
        r_r0_ctrl    <= w_dec_ctrl;
        r_r0_illegal <= w_dec_illegal;
        r_r0_tag     <= in_tag;
      end else begin
        r_r1_valid   <= 1'b1;
        r_r1_ctrl    <= w_dec_ctrl;
        r_r1_illegal <= w_dec_illegal;
        r_r1_tag     <= in_tag;
      end
    end else if (w_out_fire) begin
      r_r0_valid <= 1'b0;
    end
  end

  // Saturating count of illegal ops handed downstream; flush does not touch it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_illegal_cnt <= '0;
    end else if (w_out_fire && r_r0_illegal && (r_illegal_cnt != {CNT_W{1'b1}})) begin
      r_illegal_cnt <= r_illegal_cnt + CNT_W'(1);
    end
  end

  assign out_valid    = r_r0_valid;
  assign out_alu_ctrl = r_r0_ctrl;
  assign out_illegal  = r_r0_illegal;
  assign out_tag      = r_r0_tag;
  assign illegal_cnt  = r_illegal_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_ctrl_pipe
// Description : Self-checking bench for alu_ctrl_pipe: decode vector table,
//               handshake/flush sequences and a randomized run against a
//               pattern-table decode model and a queue model of the buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_ctrl_pipe;

  localparam logic [4:0] K_ADD = 5'd0,  K_SUB = 5'd1,  K_AND = 5'd2,  K_OR = 5'd3;
  localparam logic [4:0] K_XOR = 5'd4,  K_SLL = 5'd5,  K_SRL = 5'd6,  K_SRA = 5'd7;
  localparam logic [4:0] K_SLT = 5'd8,  K_SLTU = 5'd9, K_SH1 = 5'd10, K_SH2 = 5'd11;
  localparam logic [4:0] K_SH3 = 5'd12, K_ADDUW = 5'd13, K_SH1UW = 5'd14, K_SH2UW = 5'd15;
  localparam logic [4:0] K_SH3UW = 5'd16, K_ADDW = 5'd17, K_SUBW = 5'd18, K_SLLW = 5'd19;
  localparam logic [4:0] K_SRLW = 5'd20, K_SRAW = 5'd21, K_SLLIUW = 5'd22;

  logic       clk = 1'b0;
  logic       rst_n, flush, in_valid, out_ready;
  logic [3:0] in_alu_op;
  logic [2:0] in_funct3;
  logic [6:0] in_funct7;
  logic       in_is_imm, in_word;
  logic [7:0] in_tag;

  logic        in_ready1, out_valid1, out_illegal1;
  logic [4:0]  out_ctrl1;
  logic [7:0]  out_tag1;
  logic [15:0] cnt1;
  logic        in_ready2, out_valid2, out_illegal2;
  logic [4:0]  out_ctrl2;
  logic [7:0]  out_tag2;
  logic [1:0]  cnt2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_ctrl_pipe dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_alu_op(in_alu_op), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_is_imm(in_is_imm), .in_word(in_word), .in_tag(in_tag),
    .out_valid(out_valid1), .out_ready(out_ready), .out_alu_ctrl(out_ctrl1),
    .out_illegal(out_illegal1), .out_tag(out_tag1), .illegal_cnt(cnt1)
  );

  alu_ctrl_pipe #(.TAG_W(8), .CNT_W(2), .ENABLE_ZBA(0), .ENABLE_RV64W(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
    .in_alu_op(in_alu_op), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_is_imm(in_is_imm), .in_word(in_word), .in_tag(in_tag),
    .out_valid(out_valid2), .out_ready(out_ready), .out_alu_ctrl(out_ctrl2),
    .out_illegal(out_illegal2), .out_tag(out_tag2), .illegal_cnt(cnt2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic imm, input logic word, input logic [7:0] tag);
    in_alu_op = op; in_funct3 = f3; in_funct7 = f7;
    in_is_imm = imm; in_word = word; in_tag = tag;
  endtask

  // ---------------- decode reference: list of legal encodings ----------------
  typedef struct {
    logic [3:0] op;
    logic [2:0] f3;
    logic [2:0] f3m;
    logic [6:0] f7;
    logic [6:0] f7m;
    int         imm;   // 2 = either form
    int         word;  // 2 = either
    logic [4:0] ctrl;
  } pat_t;
  pat_t pats[$];

  task automatic add_pat(input logic [3:0] op, input logic [2:0] f3, input logic [2:0] f3m,
                         input logic [6:0] f7, input logic [6:0] f7m, input int imm,
                         input int word, input logic [4:0] ctrl);
    pat_t p;
    p.op = op; p.f3 = f3; p.f3m = f3m; p.f7 = f7; p.f7m = f7m;
    p.imm = imm; p.word = word; p.ctrl = ctrl;
    pats.push_back(p);
  endtask

  task automatic build_pats();
    add_pat(4'd0, 3'd0, 3'd0, 7'h00, 7'h00, 2, 2, K_ADD);
    add_pat(4'd1, 3'd0, 3'd7, 7'h00, 7'h00, 1, 0, K_ADD);
    add_pat(4'd1, 3'd0, 3'd7, 7'h00, 7'h00, 1, 1, K_ADDW);
    add_pat(4'd1, 3'd0, 3'd7, 7'h00, 7'h7F, 0, 0, K_ADD);
    add_pat(4'd1, 3'd0, 3'd7, 7'h00, 7'h7F, 0, 1, K_ADDW);
    add_pat(4'd1, 3'd0, 3'd7, 7'h20, 7'h7F, 0, 0, K_SUB);
    add_pat(4'd1, 3'd0, 3'd7, 7'h20, 7'h7F, 0, 1, K_SUBW);
    add_pat(4'd2, 3'd7, 3'd7, 7'h00, 7'h00, 1, 0, K_AND);
    add_pat(4'd2, 3'd7, 3'd7, 7'h00, 7'h7F, 0, 0, K_AND);
    add_pat(4'd2, 3'd6, 3'd7, 7'h00, 7'h00, 1, 0, K_OR);
    add_pat(4'd2, 3'd6, 3'd7, 7'h00, 7'h7F, 0, 0, K_OR);
    add_pat(4'd2, 3'd4, 3'd7, 7'h00, 7'h00, 1, 0, K_XOR);
    add_pat(4'd2, 3'd4, 3'd7, 7'h00, 7'h7F, 0, 0, K_XOR);
    add_pat(4'd3, 3'd1, 3'd7, 7'h00, 7'h7E, 1, 0, K_SLL);
    add_pat(4'd3, 3'd1, 3'd7, 7'h00, 7'h7F, 0, 0, K_SLL);
    add_pat(4'd3, 3'd1, 3'd7, 7'h00, 7'h7F, 2, 1, K_SLLW);
    add_pat(4'd3, 3'd5, 3'd7, 7'h00, 7'h7E, 1, 0, K_SRL);
    add_pat(4'd3, 3'd5, 3'd7, 7'h00, 7'h7F, 0, 0, K_SRL);
    add_pat(4'd3, 3'd5, 3'd7, 7'h00, 7'h7F, 2, 1, K_SRLW);
    add_pat(4'd3, 3'd5, 3'd7, 7'h20, 7'h7E, 1, 0, K_SRA);
    add_pat(4'd3, 3'd5, 3'd7, 7'h20, 7'h7F, 0, 0, K_SRA);
    add_pat(4'd3, 3'd5, 3'd7, 7'h20, 7'h7F, 2, 1, K_SRAW);
    add_pat(4'd4, 3'd2, 3'd7, 7'h00, 7'h00, 1, 0, K_SLT);
    add_pat(4'd4, 3'd2, 3'd7, 7'h00, 7'h7F, 0, 0, K_SLT);
    add_pat(4'd4, 3'd3, 3'd7, 7'h00, 7'h00, 1, 0, K_SLTU);
    add_pat(4'd4, 3'd3, 3'd7, 7'h00, 7'h7F, 0, 0, K_SLTU);
    add_pat(4'd5, 3'd2, 3'd7, 7'h10, 7'h7F, 0, 0, K_SH1);
    add_pat(4'd5, 3'd4, 3'd7, 7'h10, 7'h7F, 0, 0, K_SH2);
    add_pat(4'd5, 3'd6, 3'd7, 7'h10, 7'h7F, 0, 0, K_SH3);
    add_pat(4'd5, 3'd0, 3'd7, 7'h04, 7'h7F, 0, 1, K_ADDUW);
    add_pat(4'd5, 3'd2, 3'd7, 7'h10, 7'h7F, 0, 1, K_SH1UW);
    add_pat(4'd5, 3'd4, 3'd7, 7'h10, 7'h7F, 0, 1, K_SH2UW);
    add_pat(4'd5, 3'd6, 3'd7, 7'h10, 7'h7F, 0, 1, K_SH3UW);
    add_pat(4'd5, 3'd1, 3'd7, 7'h04, 7'h7E, 1, 1, K_SLLIUW);
  endtask

  function automatic void ref_decode(input logic [3:0] op, input logic [2:0] f3,
                                     input logic [6:0] f7, input logic imm, input logic word,
                                     input bit zba, input bit rv64,
                                     output logic [4:0] c, output logic ill);
    c = K_ADD;
    ill = 1'b1;
    foreach (pats[k]) begin
      if (ill && pats[k].op == op && ((f3 ^ pats[k].f3) & pats[k].f3m) == 3'd0 &&
          ((f7 ^ pats[k].f7) & pats[k].f7m) == 7'd0 &&
          (pats[k].imm == 2 || pats[k].imm == int'(imm)) &&
          (pats[k].word == 2 || pats[k].word == int'(word))) begin
        c = pats[k].ctrl;
        ill = 1'b0;
      end
    end
    if (!zba && op == 4'd5) ill = 1'b1;
    if (!rv64 && word) ill = 1'b1;
    if (ill) c = K_ADD;
  endfunction

  // ---------------- directed decode vectors ----------------
  typedef struct {
    logic [3:0] op; logic [2:0] f3; logic [6:0] f7; logic imm; logic word; logic [7:0] tag;
    logic [4:0] c1; logic i1; logic [4:0] c2; logic i2;
  } vec_t;
  vec_t vt[$];

  task automatic v(input logic [3:0] op, input logic [2:0] f3, input logic [6:0] f7,
                   input logic imm, input logic word, input logic [7:0] tag,
                   input logic [4:0] c1, input logic i1, input logic [4:0] c2, input logic i2);
    vec_t e;
    e.op = op; e.f3 = f3; e.f7 = f7; e.imm = imm; e.word = word; e.tag = tag;
    e.c1 = c1; e.i1 = i1; e.c2 = c2; e.i2 = i2;
    vt.push_back(e);
  endtask

  // ---------------- random-run model ----------------
  typedef struct { logic [4:0] c1; logic i1; logic [4:0] c2; logic i2; logic [7:0] tag; } exp_t;
  exp_t q[$];
  int   m_cnt1, m_cnt2;

  initial begin
    logic [4:0] c;
    logic       il;
    int         n_ill1, n_ill2;
    bit         m_out_fire, m_in_fire;
    exp_t       e;

    build_pats();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(4'd0, 3'd0, 7'd0, 1'b0, 1'b0, 8'd0);

    // reset state
    nxt(); nxt();
    chk("rst_out_valid", 32'(out_valid1), 32'd0);
    chk("rst_in_ready", 32'(in_ready1), 32'd1);
    chk("rst_out_illegal", 32'(out_illegal1), 32'd0);
    chk("rst_out_ctrl", 32'(out_ctrl1), 32'd0);
    chk("rst_out_tag", 32'(out_tag1), 32'd0);
    chk("rst_cnt", 32'(cnt1), 32'd0);
    rst_n = 1'b1;

    // decode table: op f3 f7 imm word tag | dut1 ctrl,ill | dut2 (no Zba, no RV64W) ctrl,ill
    v(4'h0, 3'd0, 7'h00, 0, 0, 8'h01, K_ADD,   0, K_ADD,  0);
    v(4'h0, 3'd5, 7'h7F, 0, 1, 8'h02, K_ADD,   0, K_ADD,  1);
    v(4'h1, 3'd0, 7'h20, 1, 0, 8'h03, K_ADD,   0, K_ADD,  0);
    v(4'h1, 3'd0, 7'h20, 0, 0, 8'h04, K_SUB,   0, K_SUB,  0);
    v(4'h1, 3'd0, 7'h20, 0, 1, 8'h05, K_SUBW,  0, K_ADD,  1);
    v(4'h1, 3'd0, 7'h7F, 1, 1, 8'h06, K_ADDW,  0, K_ADD,  1);
    v(4'h1, 3'd1, 7'h00, 0, 0, 8'h07, K_ADD,   1, K_ADD,  1);
    v(4'h1, 3'd0, 7'h01, 0, 0, 8'h08, K_ADD,   1, K_ADD,  1);
    v(4'h2, 3'd7, 7'h00, 0, 0, 8'h09, K_AND,   0, K_AND,  0);
    v(4'h2, 3'd4, 7'h55, 1, 0, 8'h0A, K_XOR,   0, K_XOR,  0);
    v(4'h2, 3'd6, 7'h00, 1, 0, 8'h0B, K_OR,    0, K_OR,   0);
    v(4'h2, 3'd7, 7'h00, 0, 1, 8'h0C, K_ADD,   1, K_ADD,  1);
    v(4'h2, 3'd6, 7'h20, 0, 0, 8'h0D, K_ADD,   1, K_ADD,  1);
    v(4'h2, 3'd5, 7'h00, 0, 0, 8'h0E, K_ADD,   1, K_ADD,  1);
    v(4'h3, 3'd5, 7'h21, 1, 0, 8'h0F, K_SRA,   0, K_SRA,  0);
    v(4'h3, 3'd1, 7'h01, 1, 0, 8'h10, K_SLL,   0, K_SLL,  0);
    v(4'h3, 3'd5, 7'h21, 1, 1, 8'h11, K_ADD,   1, K_ADD,  1);
    v(4'h3, 3'd5, 7'h00, 0, 1, 8'h12, K_SRLW,  0, K_ADD,  1);
    v(4'h3, 3'd5, 7'h20, 0, 1, 8'h13, K_SRAW,  0, K_ADD,  1);
    v(4'h3, 3'd1, 7'h00, 1, 1, 8'h14, K_SLLW,  0, K_ADD,  1);
    v(4'h3, 3'd1, 7'h20, 0, 0, 8'h15, K_ADD,   1, K_ADD,  1);
    v(4'h3, 3'd5, 7'h00, 0, 0, 8'h16, K_SRL,   0, K_SRL,  0);
    v(4'h4, 3'd3, 7'h00, 0, 0, 8'h17, K_SLTU,  0, K_SLTU, 0);
    v(4'h4, 3'd2, 7'h7F, 1, 0, 8'h18, K_SLT,   0, K_SLT,  0);
    v(4'h4, 3'd2, 7'h01, 0, 0, 8'h19, K_ADD,   1, K_ADD,  1);
    v(4'h5, 3'd2, 7'h10, 0, 0, 8'h1A, K_SH1,   0, K_ADD,  1);
    v(4'h5, 3'd4, 7'h10, 0, 1, 8'h5A, K_SH2UW, 0, K_ADD,  1);
    v(4'h5, 3'd0, 7'h04, 0, 1, 8'h1B, K_ADDUW, 0, K_ADD,  1);
    v(4'h5, 3'd1, 7'h05, 1, 1, 8'h1C, K_SLLIUW,0, K_ADD,  1);
    v(4'h5, 3'd1, 7'h04, 1, 0, 8'h1D, K_ADD,   1, K_ADD,  1);
    v(4'h5, 3'd6, 7'h10, 0, 0, 8'h1E, K_SH3,   0, K_ADD,  1);
    v(4'h5, 3'd6, 7'h10, 0, 1, 8'h1F, K_SH3UW, 0, K_ADD,  1);
    v(4'h5, 3'd2, 7'h10, 1, 0, 8'h20, K_ADD,   1, K_ADD,  1);
    v(4'h6, 3'd0, 7'h00, 0, 0, 8'h21, K_ADD,   1, K_ADD,  1);
    v(4'hF, 3'd0, 7'h00, 0, 0, 8'h22, K_ADD,   1, K_ADD,  1);

    // back-to-back with out_ready=1: every op shows up exactly one cycle later
    n_ill1 = 0; n_ill2 = 0;
    out_ready = 1'b1;
    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].op, vt[i].f3, vt[i].f7, vt[i].imm, vt[i].word, vt[i].tag);
      in_valid = 1'b1;
      nxt();
      chk($sformatf("vec%0d_valid", i), 32'(out_valid1), 32'd1);
      chk($sformatf("vec%0d_ctrl", i), 32'(out_ctrl1), 32'(vt[i].c1));
      chk($sformatf("vec%0d_ill", i), 32'(out_illegal1), 32'(vt[i].i1));
      chk($sformatf("vec%0d_tag", i), 32'(out_tag1), 32'(vt[i].tag));
      chk($sformatf("vec%0d_ctrl2", i), 32'(out_ctrl2), 32'(vt[i].c2));
      chk($sformatf("vec%0d_ill2", i), 32'(out_illegal2), 32'(vt[i].i2));
      if (vt[i].i1) n_ill1++;
      if (vt[i].i2) n_ill2++;
    end
    in_valid = 1'b0;
    nxt();
    chk("vec_drained", 32'(out_valid1), 32'd0);
    chk("vec_cnt1", 32'(cnt1), 32'(n_ill1));
    chk("vec_cnt2_sat", 32'(cnt2), 32'((n_ill2 > 3) ? 3 : n_ill2));

    // stall: three back-to-back ops against out_ready=0
    rst_n = 1'b0; nxt(); rst_n = 1'b1;
    chk("rst_clears_cnt2", 32'(cnt2), 32'd0);
    out_ready = 1'b0;
    drive(4'd0, 3'd0, 7'd0, 0, 0, 8'hA1); in_valid = 1'b1;
    nxt();
    chk("stall_a_valid", 32'(out_valid1), 32'd1);
    chk("stall_a_tag", 32'(out_tag1), 32'hA1);
    chk("stall_ready_after_1", 32'(in_ready1), 32'd1);
    drive(4'd0, 3'd0, 7'd0, 0, 0, 8'hB2);
    nxt();
    chk("stall_ready_after_2", 32'(in_ready1), 32'd0);
    chk("stall_a_hold", 32'(out_tag1), 32'hA1);
    drive(4'd0, 3'd0, 7'd0, 0, 0, 8'hC3);
    nxt();
    chk("stall_ready_held", 32'(in_ready1), 32'd0);
    chk("stall_a_hold2", 32'(out_tag1), 32'hA1);
    out_ready = 1'b1;
    nxt();
    chk("stall_b_tag", 32'(out_tag1), 32'hB2);
    chk("stall_ready_back", 32'(in_ready1), 32'd1);
    nxt();
    chk("stall_c_tag", 32'(out_tag1), 32'hC3);
    chk("stall_c_valid", 32'(out_valid1), 32'd1);
    in_valid = 1'b0;
    nxt();
    chk("stall_empty", 32'(out_valid1), 32'd0);

    // flush with both entries full and a beat on the input
    out_ready = 1'b0;
    drive(4'd0, 3'd0, 7'd0, 0, 0, 8'h11); in_valid = 1'b1;
    nxt();
    drive(4'd0, 3'd0, 7'd0, 0, 0, 8'h22);
    nxt();
    chk("flush_pre_full", 32'(in_ready1), 32'd0);
    drive(4'd0, 3'd0, 7'd0, 0, 0, 8'h33);
    flush = 1'b1;
    nxt();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", 32'(out_valid1), 32'd0);
    chk("flush_in_ready", 32'(in_ready1), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nxt();
      chk("flush_no_ghost", 32'(out_valid1), 32'd0);
    end

    // randomized run against the queue model
    rst_n = 1'b0; nxt(); rst_n = 1'b1;
    q.delete(); m_cnt1 = 0; m_cnt2 = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      chk("rnd_out_valid", 32'(out_valid1), 32'(q.size() > 0));
      chk("rnd_in_ready", 32'(in_ready1), 32'(q.size() < 2));
      chk("rnd_in_ready2", 32'(in_ready2), 32'(q.size() < 2));
      chk("rnd_cnt1", 32'(cnt1), 32'(m_cnt1));
      chk("rnd_cnt2", 32'(cnt2), 32'(m_cnt2));
      if (q.size() > 0) begin
        chk("rnd_ctrl", 32'(out_ctrl1), 32'(q[0].c1));
        chk("rnd_ill", 32'(out_illegal1), 32'(q[0].i1));
        chk("rnd_tag", 32'(out_tag1), 32'(q[0].tag));
        chk("rnd_ctrl2", 32'(out_ctrl2), 32'(q[0].c2));
        chk("rnd_ill2", 32'(out_illegal2), 32'(q[0].i2));
      end
      in_alu_op = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 5)) : 4'($urandom_range(0, 15));
      in_funct3 = 3'($urandom);
      case ($urandom_range(0, 7))
        0: in_funct7 = 7'h00;
        1: in_funct7 = 7'h20;
        2: in_funct7 = 7'h10;
        3: in_funct7 = 7'h04;
        4: in_funct7 = 7'h05;
        5: in_funct7 = 7'h21;
        6: in_funct7 = 7'h01;
        default: in_funct7 = 7'($urandom);
      endcase
      in_is_imm = 1'($urandom);
      in_word   = 1'($urandom);
      in_tag    = 8'($urandom);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 99) < 3);
      rst_n     = ($urandom_range(0, 199) != 0);
      m_out_fire = (q.size() > 0) && out_ready;
      m_in_fire  = in_valid && (q.size() < 2);
      ref_decode(in_alu_op, in_funct3, in_funct7, in_is_imm, in_word, 1'b1, 1'b1, c, il);
      e.c1 = c; e.i1 = il;
      ref_decode(in_alu_op, in_funct3, in_funct7, in_is_imm, in_word, 1'b0, 1'b0, c, il);
      e.c2 = c; e.i2 = il; e.tag = in_tag;
      @(posedge clk);
      if (!rst_n) begin
        q.delete(); m_cnt1 = 0; m_cnt2 = 0;
      end else begin
        if (m_out_fire) begin
          if (q[0].i1 && m_cnt1 != 65535) m_cnt1++;
          if (q[0].i2 && m_cnt2 != 3) m_cnt2++;
        end
        if (flush) begin
          q.delete();
        end else begin
          if (m_out_fire) void'(q.pop_front());
          if (m_in_fire) q.push_back(e);
        end
      end
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
